wb2axi_req_arbiter: RTL and testbench

- Round-robin, burst-aware arbiter that shares one wb2axi_buffer write port among NUM_REQ Wishbone-side requesters.
- Each requester presents a valid/ready stream of flits with a last marker.
- The arbiter grants one requester, holds the grant until its last flit is accepted, tags each flit with the requester ID, then rotates priority.
- Sits directly upstream of the buffer's valid_i/data_i/ready_o interface.

---
 rtl/wb2axi_pkg.sv | 24 ++
 rtl/wb2axi_rr_picker.sv | 41 ++++
 rtl/wb2axi_req_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb2axi_req_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb2axi_pkg.sv
// Shared types and constant helpers for the wb2axi bridge.
// Imported by the arbiter and its round-robin picker.
package wb2axi_pkg;

    // Ceiling log2; log2(1) == 0.
    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : log2(n);
    endfunction

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb2axi_rr_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr.
// Returns a one-hot grant, its binary index and an any-request flag.
module wb2axi_rr_picker
    import wb2axi_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_req,
    input  logic [ID_WIDTH-1:0] i_ptr,
    output logic [NUM_REQ-1:0]  o_gnt,
    output logic [ID_WIDTH-1:0] o_idx,
    output logic                o_any
);

    logic                w_found;
    logic [ID_WIDTH-1:0] w_k;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int k;
            k = int'(i_ptr) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            w_k = ID_WIDTH'(k);
            if (!w_found && i_req[w_k]) begin
                w_found    = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = w_k;
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/wb2axi_req_arbiter.sv
// Burst-aware round-robin arbiter feeding the wb2axi_buffer write port.
// Locks onto a requester until its last flit is accepted.
module wb2axi_req_arbiter
    import wb2axi_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = id_width(NUM_REQ),
    parameter int MAX_BEATS  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          valid_o,
    output logic [DATA_WIDTH-1:0]         data_o,
    output logic                          last_o,
    output logic [ID_WIDTH-1:0]           id_o,
    input  logic                          ready_i,
    output logic                          busy_o,
    output logic                          err_o
);

    localparam int CW = log2(MAX_BEATS) + 1;
    localparam logic [CW-1:0] MAXB = CW'(MAX_BEATS);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [ID_WIDTH-1:0] r_prio_ptr;
    logic [ID_WIDTH-1:0] w_prio_nxt;
    logic [ID_WIDTH-1:0] r_lock_id;
    logic [ID_WIDTH-1:0] w_lock_nxt;
    logic [CW-1:0]       r_beat_cnt;
    logic [CW-1:0]       w_beat_nxt;
    logic                r_err;
    logic                w_err_nxt;

    logic [NUM_REQ-1:0]    w_pick_gnt;
    logic [ID_WIDTH-1:0]   w_pick_idx;
    logic                  w_pick_any;
    logic                  w_locked;
    logic [ID_WIDTH-1:0]   w_sel;
    logic [ID_WIDTH-1:0]   w_next_ptr;
    logic                  w_valid;
    logic                  w_last;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] w_data;
    logic [NUM_REQ-1:0]    w_ready;

    wb2axi_rr_picker #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_picker (
        .i_req (req_valid_i),
        .i_ptr (r_prio_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_locked = (r_state == ARB_LOCKED);
    assign w_sel    = w_locked ? r_lock_id : w_pick_idx;
    assign w_valid  = w_locked ? req_valid_i[w_sel] : w_pick_any;
    assign w_data   = req_data_i[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
    assign w_last   = req_last_i[w_sel];
    assign w_hs     = w_valid & ready_i;

    assign w_next_ptr = (w_sel == ID_WIDTH'(NUM_REQ - 1)) ?
                        '0 : w_sel + 1'b1;

    always_comb begin
        w_ready = '0;
        if (w_locked) begin
            w_ready[w_sel] = ready_i;
        end else if (w_pick_any) begin
            w_ready = w_pick_gnt & {NUM_REQ{ready_i}};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ARB_IDLE;
            r_prio_ptr <= '0;
            r_lock_id  <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_prio_ptr <= w_prio_nxt;
            r_lock_id  <= w_lock_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio_ptr;
        w_lock_nxt  = r_lock_id;
        w_beat_nxt  = r_beat_cnt;
        w_err_nxt   = r_err | (w_hs && (r_beat_cnt == MAXB));
        unique case (r_state)
            ARB_IDLE: begin
                if (w_hs && w_last) begin
                    w_prio_nxt = w_next_ptr;
                    w_beat_nxt = '0;
                end else if (w_valid) begin
                    // Lock even on a stall so a pending flit never
                    // changes source under backpressure.
                    w_lock_nxt  = w_sel;
                    w_state_nxt = ARB_LOCKED;
                    if (w_hs) begin
                        w_beat_nxt = CW'(1);
                    end
                end
            end
            ARB_LOCKED: begin
                if (w_hs && w_last) begin
                    w_prio_nxt  = w_next_ptr;
                    w_state_nxt = ARB_IDLE;
                    w_beat_nxt  = '0;
                end else if (w_hs && (r_beat_cnt != MAXB)) begin
                    w_beat_nxt = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // No grant exists while reset is held, so the datapath is forced quiet.
    assign valid_o     = rst_ni & w_valid;
    assign data_o      = rst_ni ? w_data : '0;
    assign last_o      = rst_ni & w_last;
    assign id_o        = rst_ni ? w_sel : '0;
    assign req_ready_o = w_ready & {NUM_REQ{rst_ni}};
    assign busy_o      = rst_ni & w_locked;
    assign err_o       = r_err;

endmodule

// File: tb/tb_wb2axi_req_arbiter.sv
// Scoreboard bench for wb2axi_req_arbiter (4 requesters, MAX_BEATS=4).
// Requester queues feed flits; expected grants are queued in order.
module tb_wb2axi_req_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;
    localparam int MB = 4;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic [NR-1:0]    req_valid_i = '0;
    logic [NR*DW-1:0] req_data_i = '0;
    logic [NR-1:0]    req_last_i = '0;
    logic [NR-1:0]    req_ready_o;
    logic             valid_o;
    logic [DW-1:0]    data_o;
    logic             last_o;
    logic [IW-1:0]    id_o;
    logic             ready_i = 1'b1;
    logic             busy_o;
    logic             err_o;

    logic [DW:0]   rq [NR][$];
    exp_t          sb [$];
    logic [NR-1:0] fire = '0;
    int            n_tests = 0;
    int            n_fail = 0;

    wb2axi_req_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .valid_o     (valid_o),
        .data_o      (data_o),
        .last_o      (last_o),
        .id_o        (id_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic [DW-1:0] d,
                         input logic l);
        rq[k].push_back({l, d});
    endtask

    task automatic send(input int k, input logic [DW-1:0] d,
                        input logic l);
        exp_t e;
        drive(k, d, l);
        e.id   = IW'(k);
        e.data = d;
        e.last = l;
        sb.push_back(e);
    endtask

    task automatic wait_hs(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!(valid_o && ready_i) && n < 50);
        check(tag, valid_o && ready_i, 1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, sb.size(), 0);
        @(posedge clk_i);
        #1;
    endtask

    // Requester streams: pop on accepted flit, present queue heads.
    always begin
        @(posedge clk_i);
        #2;
        for (int k = 0; k < NR; k++) begin
            if (fire[k] && rq[k].size() > 0) begin
                void'(rq[k].pop_front());
            end
            if (rq[k].size() > 0) begin
                req_valid_i[k]             = 1'b1;
                req_data_i[k*DW +: DW]     = rq[k][0][DW-1:0];
                req_last_i[k]              = rq[k][0][DW];
            end else begin
                req_valid_i[k]             = 1'b0;
                req_data_i[k*DW +: DW]     = '0;
                req_last_i[k]              = 1'b0;
            end
        end
        @(negedge clk_i);
        fire = req_valid_i & req_ready_o;
    end

    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_flit", {id_o, data_o}, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_id", id_o, e.id);
                check("sb_data", data_o, e.data);
                check("sb_last", last_o, e.last);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Outputs quiet during reset even with a pending request.
        @(posedge clk_i);
        #1;
        send(1, 32'h11, 1'b1);
        @(negedge clk_i);
        check("rst_valid", valid_o, 0);
        check("rst_ready", req_ready_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        check("rst_data", data_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        drain("t0_drain");

        // Single 3-flit burst on requester 2.
        send(2, 32'hA0, 1'b0);
        send(2, 32'hA1, 1'b0);
        send(2, 32'hA2, 1'b1);
        wait_hs("t1_hs0");
        check("t1_busy0", busy_o, 0);
        wait_hs("t1_hs1");
        check("t1_busy1", busy_o, 1);
        wait_hs("t1_hs2");
        check("t1_busy2", busy_o, 1);
        @(negedge clk_i);
        check("t1_busy_end", busy_o, 0);
        check("t1_valid_end", valid_o, 0);
        @(posedge clk_i);
        #1;

        // Fairness: priority now starts at 3.
        for (int j = 0; j < 2; j++) begin
            for (int i = 0; i < NR; i++) begin
                int k;
                k = (3 + i) % NR;
                send(k, 32'hB000_0000 | (k << 4) | j, 1'b1);
            end
        end
        drain("t2_drain");

        // Move priority to 1, then lock on 1 under contention.
        send(0, 32'hC0, 1'b1);
        drain("t3_pre");
        for (int j = 0; j < 4; j++) begin
            send(1, 32'hC100 + j, (j == 3));
        end
        send(2, 32'hC2, 1'b1);
        send(3, 32'hC3, 1'b1);
        send(0, 32'hC4, 1'b1);
        for (int j = 0; j < 4; j++) begin
            wait_hs("t3_hs");
            check("t3_ready", req_ready_o, 4'b0010);
        end
        drain("t3_drain");

        // Backpressure: grant to 3 must stay put.
        ready_i = 1'b0;
        send(3, 32'hD3, 1'b1);
        @(negedge clk_i);
        check("t4_valid", valid_o, 1);
        check("t4_id0", id_o, 3);
        check("t4_busy0", busy_o, 0);
        @(posedge clk_i);
        #1;
        send(0, 32'hD0, 1'b1);
        for (int j = 0; j < 4; j++) begin
            @(negedge clk_i);
            check("t4_id", id_o, 3);
            check("t4_data", data_o, 32'hD3);
            check("t4_rdy", req_ready_o, 0);
            check("t4_busy", busy_o, 1);
        end
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
        wait_hs("t4_hs");
        check("t4_hs_id", id_o, 3);
        drain("t4_drain");

        // Overlength burst: 6 flits, err on the 5th handshake.
        for (int j = 0; j < 5; j++) begin
            send(0, 32'hE0 + j, 1'b0);
        end
        send(0, 32'hE5, 1'b1);
        for (int j = 0; j < 5; j++) begin
            wait_hs("t5_hs");
            check("t5_err_lo", err_o, 0);
        end
        wait_hs("t5_hs5");
        check("t5_err_hi", err_o, 1);
        drain("t5_drain");
        repeat (2) @(negedge clk_i);
        check("t5_err_sticky", err_o, 1);
        check("t5_busy", busy_o, 0);
        @(posedge clk_i);
        #1;

        // Reset in the middle of a 4-flit burst.
        send(2, 32'hF0, 1'b0);
        send(2, 32'hF1, 1'b0);
        drive(2, 32'hF2, 1'b0);
        drive(2, 32'hF3, 1'b1);
        wait_hs("t6_hs0");
        wait_hs("t6_hs1");
        check("t6_busy_pre", busy_o, 1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("t6_valid", valid_o, 0);
        check("t6_busy", busy_o, 0);
        check("t6_err", err_o, 0);
        check("t6_ready", req_ready_o, 0);
        @(posedge clk_i);
        #1;
        rq[2].delete();
        send(0, 32'h90, 1'b1);
        send(1, 32'h91, 1'b1);
        send(3, 32'h93, 1'b1);
        @(negedge clk_i);
        check("t6_valid_rst", valid_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("t6_first_id", id_o, 0);
        drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
